// File: rtl/mac_acc_pkg.sv
// Shared widths, FSM state type and operand helpers for the MAC product accumulator.
// MAC_ACC_SATURATE_EN adds the clamp-value helpers used by the saturating build.
package mac_acc_pkg;

   localparam int PROD_W  = 12;
   localparam int ACC_W   = 24;
   localparam int CNT_W   = 8;
   localparam int LANE_PW = PROD_W / 2;
   localparam int LANE_AW = ACC_W / 2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_e;

   function automatic logic [LANE_AW-1:0] ext_lane(input logic [LANE_PW-1:0] p,
                                                    input logic             sgn);
      return {{(LANE_AW-LANE_PW){sgn & p[LANE_PW-1]}}, p};
   endfunction

   // Half mode widens each lane on its own so lane1 never sees lane0's sign.
   function automatic logic [ACC_W-1:0] ext_prod(input logic [PROD_W-1:0] p,
                                                 input logic              half,
                                                 input logic              sgn);
      if (half) begin
         return {ext_lane(p[PROD_W-1:LANE_PW], sgn), ext_lane(p[LANE_PW-1:0], sgn)};
      end
      return {{(ACC_W-PROD_W){sgn & p[PROD_W-1]}}, p};
   endfunction

`ifdef MAC_ACC_SATURATE_EN
   function automatic logic [LANE_AW-1:0] clamp_lane(input logic sgn, input logic neg);
      if (!sgn) begin
         return '1;
      end
      return neg ? {1'b1, {(LANE_AW-1){1'b0}}} : {1'b0, {(LANE_AW-1){1'b1}}};
   endfunction

   function automatic logic [ACC_W-1:0] clamp_full(input logic sgn, input logic neg);
      if (!sgn) begin
         return '1;
      end
      return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   endfunction
`endif

endpackage

// File: rtl/mac_lane_acc.sv
// One ACC_W/2-bit accumulator lane adder with carry-in/carry-out for chaining.
// With MAC_ACC_SATURATE_EN it also flags overflow and can clamp its own result.
module mac_lane_acc
   import mac_acc_pkg::*;
(
   input  logic [LANE_AW-1:0] a_i,
   input  logic [LANE_AW-1:0] b_i,
   input  logic               cin_i,
`ifdef MAC_ACC_SATURATE_EN
   input  logic               sign_i,
   input  logic               clamp_en_i,
   output logic               ovf_o,
`endif
   output logic [LANE_AW-1:0] sum_o,
   output logic               cout_o
);

   logic [LANE_AW:0] raw;

   assign raw    = {1'b0, a_i} + {1'b0, b_i} + {{LANE_AW{1'b0}}, cin_i};
   assign cout_o = raw[LANE_AW];

`ifdef MAC_ACC_SATURATE_EN
   // Signed overflow only happens when both operands share a sign, so a_i's MSB picks the rail.
   assign ovf_o = sign_i ? ((a_i[LANE_AW-1] == b_i[LANE_AW-1]) &&
                            (raw[LANE_AW-1] != a_i[LANE_AW-1]))
                         : raw[LANE_AW];
   assign sum_o = (clamp_en_i && ovf_o) ? clamp_lane(sign_i, a_i[LANE_AW-1])
                                        : raw[LANE_AW-1:0];
`else
   assign sum_o = raw[LANE_AW-1:0];
`endif

endmodule

// File: rtl/mac_product_accumulator.sv
// Accumulates groups of 6x6-multiplier products as one 24-bit sum or two 12-bit lane sums.
// MAC_ACC_SATURATE_EN selects clamping adds instead of modular wrap.
//
// state | meaning
// IDLE  | no group open; next accepted beat starts a group
// ACC   | group open; beats add into the running sum
// HOLD  | result offered on out_*; a beat taken with out_ready starts the next group
module mac_product_accumulator
   import mac_acc_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_sign,
   input  logic              in_half,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              out_half,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_err
);

   state_e             state_q;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               half_q, sign_q, err_q, vld_q;

   logic               accept, first, mode_half, mode_sign, mismatch;
   logic [ACC_W-1:0]   base, addend, sum_raw;
   logic [LANE_AW-1:0] l0_sum, l1_sum;
   logic               l0_cout, l1_cin, l1_cout_unused;

   assign in_ready  = (state_q != HOLD) | out_ready;
   assign accept    = in_valid & in_ready;
   assign first     = (state_q != ACC);

   // Later beats are interpreted with the group's latched mode, never the beat's own flags.
   assign mode_half = first ? in_half : half_q;
   assign mode_sign = first ? in_sign : sign_q;
   assign mismatch  = !first & ((in_half != half_q) | (in_sign != sign_q));

   assign base      = first ? '0 : acc_q;
   assign addend    = ext_prod(in_prod, mode_half, mode_sign);
   assign l1_cin    = mode_half ? 1'b0 : l0_cout;
   assign sum_raw   = {l1_sum, l0_sum};

   assign cnt_d     = first ? CNT_ONE : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE);

`ifdef MAC_ACC_SATURATE_EN
   logic [1:0] sat_q, sat_d, hold_lane;
   logic       l0_ovf, l1_ovf;
`endif

   mac_lane_acc u_lane0 (
      .a_i        (base[LANE_AW-1:0]),
      .b_i        (addend[LANE_AW-1:0]),
      .cin_i      (1'b0),
`ifdef MAC_ACC_SATURATE_EN
      .sign_i     (mode_sign),
      .clamp_en_i (mode_half),
      .ovf_o      (l0_ovf),
`endif
      .sum_o      (l0_sum),
      .cout_o     (l0_cout)
   );

   mac_lane_acc u_lane1 (
      .a_i        (base[ACC_W-1:LANE_AW]),
      .b_i        (addend[ACC_W-1:LANE_AW]),
      .cin_i      (l1_cin),
`ifdef MAC_ACC_SATURATE_EN
      .sign_i     (mode_sign),
      .clamp_en_i (mode_half),
      .ovf_o      (l1_ovf),
`endif
      .sum_o      (l1_sum),
      .cout_o     (l1_cout_unused)
   );

`ifdef MAC_ACC_SATURATE_EN
   // Once a lane (or the full word, tracked in bit 0) clamps, it holds for the rest of the group.
   assign hold_lane = first ? 2'b00 : sat_q;

   always_comb begin
      acc_d = sum_raw;
      sat_d = hold_lane;
      if (mode_half) begin
         if (hold_lane[0]) begin
            acc_d[LANE_AW-1:0] = acc_q[LANE_AW-1:0];
         end else begin
            sat_d[0] = l0_ovf;
         end
         if (hold_lane[1]) begin
            acc_d[ACC_W-1:LANE_AW] = acc_q[ACC_W-1:LANE_AW];
         end else begin
            sat_d[1] = l1_ovf;
         end
      end else begin
         if (hold_lane[0]) begin
            acc_d = acc_q;
         end else if (l1_ovf) begin
            acc_d    = clamp_full(mode_sign, base[ACC_W-1]);
            sat_d[0] = 1'b1;
         end
      end
   end
`else
   assign acc_d = sum_raw;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         half_q  <= 1'b0;
         sign_q  <= 1'b0;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
`ifdef MAC_ACC_SATURATE_EN
         sat_q   <= 2'b00;
`endif
      end else if (accept) begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
`ifdef MAC_ACC_SATURATE_EN
         sat_q <= sat_d;
`endif
         if (first) begin
            half_q <= in_half;
            sign_q <= in_sign;
         end else if (mismatch) begin
            err_q <= 1'b1;
         end
         state_q <= in_last ? HOLD : ACC;
         vld_q   <= in_last;
      end else if ((state_q == HOLD) && out_ready) begin
         state_q <= IDLE;
         vld_q   <= 1'b0;
      end
   end

   assign out_valid = vld_q;
   assign out_acc   = acc_q;
   assign out_half  = half_q;
   assign out_count = cnt_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_mac_product_accumulator.sv
// Bench for mac_product_accumulator: arithmetic group model checked every cycle plus directed literals.
// Honors MAC_ACC_SATURATE_EN to pick clamping or wrapping expectations.
module tb_mac_product_accumulator;

`ifdef MAC_ACC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0, in_sign = 1'b0, in_half = 1'b0, in_last = 1'b0;
   logic        out_ready = 1'b0;
   logic [11:0] in_prod = 12'h000;
   logic        in_ready, out_valid, out_half, out_err;
   logic [23:0] out_acc;
   logic [7:0]  out_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mac_product_accumulator dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .in_sign   (in_sign),
      .in_half   (in_half),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_half  (out_half),
      .out_count (out_count),
      .out_err   (out_err)
   );

   typedef struct packed {
      bit       hold;
      bit       ingrp;
      bit       half;
      bit       sign;
      bit       err;
      bit [1:0] sat;
      longint   l0;
      longint   l1;
      longint   full;
      int       cnt;
   } model_t;

   model_t m;

   function automatic longint sx(input longint raw, input int bits, input bit sg);
      if (sg && raw[bits-1]) return raw - (longint'(1) << bits);
      return raw;
   endfunction

   // cur is a w-bit pattern; returns the new pattern after adding the true value v.
   function automatic longint lane_add(input longint cur, input longint v, input int w,
                                       input bit sg, input bit sat_in, output bit sat_out);
      longint md, cv, t, lo, hi;
      md = longint'(1) << w;
      cv = (sg && cur >= md / 2) ? cur - md : cur;
      t  = cv + v;
      sat_out = sat_in;
      if (SAT) begin
         lo = sg ? -(md / 2) : 0;
         hi = sg ? (md / 2 - 1) : (md - 1);
         if (sat_in) t = cv;
         else if (t > hi) begin t = hi; sat_out = 1'b1; end
         else if (t < lo) begin t = lo; sat_out = 1'b1; end
      end
      return ((t % md) + md) % md;
   endfunction

   function automatic model_t step(input model_t s, input bit v, input bit rdy,
                                   input logic [11:0] p, input bit sg, input bit hf,
                                   input bit lst);
      model_t n;
      bit so;
      n = s;
      if (v && (!s.hold || rdy)) begin
         if (!s.ingrp) begin
            n.half = hf; n.sign = sg;
            n.l0 = 0; n.l1 = 0; n.full = 0; n.sat = 2'b00; n.cnt = 1;
         end else begin
            n.cnt = (s.cnt >= 255) ? 255 : s.cnt + 1;
            if (hf != s.half || sg != s.sign) n.err = 1'b1;
         end
         if (n.half) begin
            n.l0 = lane_add(n.l0, sx(longint'(p[5:0]), 6, n.sign), 12, n.sign, n.sat[0], so);
            n.sat[0] = so;
            n.l1 = lane_add(n.l1, sx(longint'(p[11:6]), 6, n.sign), 12, n.sign, n.sat[1], so);
            n.sat[1] = so;
         end else begin
            n.full = lane_add(n.full, sx(longint'(p), 12, n.sign), 24, n.sign, n.sat[0], so);
            n.sat[0] = so;
         end
         n.hold  = lst;
         n.ingrp = !lst;
      end else if (s.hold && rdy) begin
         n.hold = 1'b0;
      end
      return n;
   endfunction

   function automatic longint exp_acc(input model_t s);
      longint r;
      if (s.half) r = ((s.l1 & 64'hFFF) << 12) | (s.l0 & 64'hFFF);
      else r = s.full & 64'hFFFFFF;
      return r;
   endfunction

   task automatic chk(input string name, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rstn) begin
      if (!rstn) m <= '0;
      else m <= step(m, in_valid, out_ready, in_prod, in_sign, in_half, in_last);
   end

   always @(negedge clk) begin
      chk("in_ready", longint'(in_ready), longint'(!m.hold || out_ready));
      chk("out_valid", longint'(out_valid), longint'(m.hold));
      chk("out_err", longint'(out_err), longint'(m.err));
      if (m.hold) begin
         chk("out_acc", longint'(out_acc), exp_acc(m));
         chk("out_half", longint'(out_half), longint'(m.half));
         chk("out_count", longint'(out_count), longint'(m.cnt));
      end
   end

   // Called at the phase just after a rising edge; returns at the same phase after acceptance.
   task automatic send(input logic [11:0] p, input bit sg, input bit hf, input bit lst);
      int n;
      n = 0;
      in_valid = 1'b1; in_prod = p; in_sign = sg; in_half = hf; in_last = lst;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("send_accept", longint'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit gh, gs;
      longint lane6;
      gh = 1'b0; gs = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_acc", longint'(out_acc), 0);
      chk("rst_out_half", longint'(out_half), 0);
      chk("rst_out_count", longint'(out_count), 0);
      chk("rst_out_err", longint'(out_err), 0);
      sync();
      rstn = 1'b1;
      sync();

      send(12'hFFF, 1'b1, 1'b0, 1'b0);
      send(12'hFFF, 1'b1, 1'b0, 1'b0);
      send(12'hFFF, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("t1_valid", longint'(out_valid), 1);
      chk("t1_acc", longint'(out_acc), 64'hFFFFFD);
      chk("t1_count", longint'(out_count), 3);
      drain();

      send({6'd9, 6'd4}, 1'b0, 1'b1, 1'b0);
      send({6'd9, 6'd4}, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("t2_acc", longint'(out_acc), 64'h012008);
      chk("t2_half", longint'(out_half), 1);
      drain();

      send(12'h005, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_in_ready", longint'(in_ready), 0);
         chk("t3_hold_acc", longint'(out_acc), 5);
         chk("t3_hold_valid", longint'(out_valid), 1);
      end
      sync();
      out_ready = 1'b1;
      send(12'h001, 1'b0, 1'b0, 1'b1);
      out_ready = 1'b0;
      @(negedge clk);
      chk("t3_new_valid", longint'(out_valid), 1);
      chk("t3_new_acc", longint'(out_acc), 1);
      chk("t3_new_count", longint'(out_count), 1);
      drain();

      send(12'h007, 1'b0, 1'b0, 1'b0);
      send(12'h008, 1'b0, 1'b0, 1'b0);
      rstn = 1'b0;
      @(negedge clk);
      chk("t4_valid", longint'(out_valid), 0);
      chk("t4_acc", longint'(out_acc), 0);
      chk("t4_count", longint'(out_count), 0);
      sync();
      rstn = 1'b1;
      send(12'h003, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("t4_fresh_acc", longint'(out_acc), 3);
      chk("t4_fresh_count", longint'(out_count), 1);
      drain();

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            gh = 1'($urandom_range(0, 1));
            gs = 1'($urandom_range(0, 1));
         end
         in_valid  = ($urandom_range(0, 2) != 0);
         in_prod   = 12'($urandom);
         in_sign   = gs;
         in_half   = gh;
         in_last   = ($urandom_range(0, 4) == 0);
         out_ready = 1'($urandom_range(0, 1));
         sync();
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      sync();
      out_ready = 1'b0;
      rstn = 1'b0;
      sync();
      rstn = 1'b1;

      send({6'd1, 6'd2}, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("t5_err_before", longint'(out_err), 0);
      sync();
      send({6'd3, 6'd4}, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("t5_acc", longint'(out_acc), 64'h004006);
      chk("t5_half", longint'(out_half), 1);
      chk("t5_err", longint'(out_err), 1);
      drain();
      send(12'h001, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("t5_err_sticky", longint'(out_err), 1);
      drain();

      for (int i = 0; i < 200; i++) send({6'd16, 6'd16}, 1'b1, 1'b1, i == 199);
      @(negedge clk);
      lane6 = SAT ? 64'h7FF : 64'hC80;
      chk("t6_acc", longint'(out_acc), (lane6 << 12) | lane6);
      chk("t6_count", longint'(out_count), 200);
      drain();

      for (int i = 0; i < 260; i++) send(12'h001, 1'b0, 1'b0, i == 259);
      @(negedge clk);
      chk("t7_acc", longint'(out_acc), 260);
      chk("t7_count_sat", longint'(out_count), 255);
      drain();

      rstn = 1'b0;
      @(negedge clk);
      chk("end_rst_err", longint'(out_err), 0);
      chk("end_rst_valid", longint'(out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
